// File: rtl/register_file_multiport.sv
// ============================================================================
// Module      : register_file_multiport
// Description : NUM_REGS x DATA_W general register file with NUM_READ
//               combinational read ports, one write port, HI/LO registers
//               with a mult/div busy scoreboard, and a debug register tap.
//               Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_multiport #(
   parameter int DATA_W         = 32,
   parameter int NUM_REGS       = 32,
   parameter int ADDR_W         = $clog2(NUM_REGS),
   parameter int NUM_READ       = 2,
   parameter int NEG_EDGE_WRITE = 1,
   parameter int DEBUG_REG      = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         write_enable,
   input  logic [ADDR_W-1:0]            write_address,
   input  logic [DATA_W-1:0]            write_data,
   input  logic [NUM_READ*ADDR_W-1:0]   read_address,
   output logic [NUM_READ*DATA_W-1:0]   read_data,
   output logic [DATA_W-1:0]            read_register_debug,
   input  logic                         hilo_issue,
   input  logic                         HI_write_enable,
   input  logic                         LO_write_enable,
   input  logic [DATA_W-1:0]            HI_write_data,
   input  logic [DATA_W-1:0]            LO_write_data,
   input  logic                         hilo_read_request,
   output logic [DATA_W-1:0]            read_data_HI,
   output logic [DATA_W-1:0]            read_data_LO,
   output logic                         hilo_busy,
   output logic                         hilo_stall,
   output logic                         hilo_error
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              error_q, error_d;
   logic              hilo_wr;

   assign hilo_wr = HI_write_enable | LO_write_enable;

   // Next-state for the register array, HI/LO and the scoreboard flags.
   // Entry 0 is forced to zero so it can never hold a nonzero value.
   always_comb begin
      regs_d = regs_q;
      if (write_enable && (write_address != '0)) begin
         regs_d[write_address] = write_data;
      end
      regs_d[0] = '0;

      hi_d = HI_write_enable ? HI_write_data : hi_q;
      lo_d = LO_write_enable ? LO_write_data : lo_q;

      // A new issue always wins: the result it will produce is now outstanding
      // even if an older result lands in the same cycle.
      if (hilo_issue) begin
         busy_d = 1'b1;
      end else if (hilo_wr) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end

      // A HI/LO write with nothing outstanding means the mult/div unit and
      // the scoreboard disagree; latch it until reset.
      error_d = error_q | (hilo_wr & ~busy_q & ~hilo_issue);
   end

   generate
      if (NEG_EDGE_WRITE != 0) begin : g_neg_edge_write
         // State update on the falling edge so writeback lands mid-cycle.
         always_ff @(negedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
               hi_q    <= '0;
               lo_q    <= '0;
               busy_q  <= 1'b0;
               error_q <= 1'b0;
            end else begin
               regs_q  <= regs_d;
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               busy_q  <= busy_d;
               error_q <= error_d;
            end
         end
      end else begin : g_pos_edge_write
         // State update on the rising edge.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
               hi_q    <= '0;
               lo_q    <= '0;
               busy_q  <= 1'b0;
               error_q <= 1'b0;
            end else begin
               regs_q  <= regs_d;
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               busy_q  <= busy_d;
               error_q <= error_d;
            end
         end
      end
   endgenerate

   generate
      for (genvar p = 0; p < NUM_READ; p++) begin : g_read_port
         logic [ADDR_W-1:0] rd_addr;
         logic [DATA_W-1:0] rd_val;

         assign rd_addr = read_address[p*ADDR_W +: ADDR_W];

         // Combinational read; address 0 always reads zero.
         always_comb begin
            rd_val = (rd_addr == '0) ? '0 : regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; suppressed while reset is held.
            if (reset_n && write_enable && (write_address != '0) &&
                (write_address == rd_addr)) begin
               rd_val = write_data;
            end
`endif
         end

         assign read_data[p*DATA_W +: DATA_W] = rd_val;
      end
   endgenerate

`ifdef REGFILE_BYPASS_EN
   assign read_data_HI = (reset_n && HI_write_enable) ? HI_write_data : hi_q;
   assign read_data_LO = (reset_n && LO_write_enable) ? LO_write_data : lo_q;
`else
   assign read_data_HI = hi_q;
   assign read_data_LO = lo_q;
`endif

   assign read_register_debug = regs_q[DEBUG_REG];
   assign hilo_busy           = busy_q;
   assign hilo_stall          = hilo_read_request & busy_q;
   assign hilo_error          = error_q;

endmodule

`default_nettype wire
